dot_product_accumulator: RTL and testbench

Sequential accumulate stage downstream of the ripple-carry product/adder datapath in the matrix-multiplication engine. It consumes a stream of product terms, sums exactly VEC_LEN of them, and emits one dot-product element per vector. It has valid/ready handshakes on both sides. The running sum is formed by a structural ripple adder built from the existing project_1 full-adder cell.

---
 rtl/dot_product_accumulator_pkg.sv | 16 +
 rtl/dot_product_accumulator_acc_adder.sv | 45 ++++
 rtl/dot_product_accumulator.sv | 141 ++++++++++++++
 tb/tb_dot_product_accumulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared definitions for the dot-product accumulate stage.
//   - state_e   : accumulate FSM states (ACCUM collects terms, DONE holds result)
//   - DPA_*     : default parameter values for dot_product_accumulator
// Optional feature macro: DPA_OVERFLOW_EN (adds the out_ovf sticky carry flag).
package dot_product_accumulator_pkg;

  localparam int DPA_BIT_WIDTH    = 4;
  localparam int DPA_RESULT_WIDTH = 2 * DPA_BIT_WIDTH;
  localparam int DPA_VEC_LEN      = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/dot_product_accumulator_acc_adder.sv
// Structural ripple-carry adder for the accumulate stage.
//   project_1 : one-bit full adder cell (a, b, c_in -> sum, c_out)
//   acc_adder : RESULT_WIDTH-bit chain of project_1 cells, carry-in tied to 0
//     a_i, b_i : operands             sum_o : a_i + b_i (mod 2^RESULT_WIDTH)
//     c_out_o  : carry out of the most significant bit
// Purely combinational; all state lives in dot_product_accumulator.
module project_1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module acc_adder #(
  parameter int RESULT_WIDTH = 8
) (
  input  logic [RESULT_WIDTH-1:0] a_i,
  input  logic [RESULT_WIDTH-1:0] b_i,
  output logic [RESULT_WIDTH-1:0] sum_o,
  output logic                    c_out_o
);

  logic [RESULT_WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < RESULT_WIDTH; i++) begin : g_bit
    project_1 u_fa (
      .a     (a_i[i]),
      .b     (b_i[i]),
      .c_in  (carry[i]),
      .sum   (sum_o[i]),
      .c_out (carry[i+1])
    );
  end

  assign c_out_o = carry[RESULT_WIDTH];

endmodule

// File: rtl/dot_product_accumulator.sv
// Dot-product accumulate stage: sums exactly VEC_LEN unsigned product terms
// and presents one result per vector with valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     term handshake, in_data = product term
//   clear                 synchronous abort of the current vector (wins over handshakes)
//   out_valid/out_ready   result handshake, out_data = sum mod 2^RESULT_WIDTH
//   out_ovf               (only with DPA_OVERFLOW_EN) carry-out seen in the vector
// Optional feature macro: DPA_OVERFLOW_EN.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int BIT_WIDTH    = DPA_BIT_WIDTH,
  parameter int RESULT_WIDTH = 2 * BIT_WIDTH,
  parameter int VEC_LEN      = DPA_VEC_LEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RESULT_WIDTH-1:0] in_data,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef DPA_OVERFLOW_EN
  output logic                    out_ovf,
`endif
  output logic [RESULT_WIDTH-1:0] out_data
);

  localparam int              CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  state_e                  state_q;
  logic [RESULT_WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]        count_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic [RESULT_WIDTH-1:0] out_data_q;

  logic [RESULT_WIDTH-1:0] acc_d;
  logic [RESULT_WIDTH-1:0] sum_d;
  logic                    accept;

  // First term of a vector starts from zero regardless of acc_q.
  assign acc_d  = (count_q == '0) ? '0 : acc_q;
  assign accept = in_valid && in_ready_q;

`ifdef DPA_OVERFLOW_EN
  logic carry_d;
  logic ovf_run_q;
  logic out_ovf_q;

  acc_adder #(.RESULT_WIDTH(RESULT_WIDTH)) u_adder (
    .a_i     (acc_d),
    .b_i     (in_data),
    .sum_o   (sum_d),
    .c_out_o (carry_d)
  );

  // Sticky carry for the vector in flight; restarts on its first term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_run_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (clear) begin
      ovf_run_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (state_q == ACCUM && accept) begin
      if (count_q == '0) begin
        ovf_run_q <= carry_d;
        out_ovf_q <= 1'b0;
      end else begin
        ovf_run_q <= ovf_run_q | carry_d;
      end
      if (count_q == LAST) begin
        out_ovf_q <= ovf_run_q | carry_d;
      end
    end
  end

  assign out_ovf = out_ovf_q;
`else
  acc_adder #(.RESULT_WIDTH(RESULT_WIDTH)) u_adder (
    .a_i     (acc_d),
    .b_i     (in_data),
    .sum_o   (sum_d),
    .c_out_o ()
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= sum_d;
            if (count_q == LAST) begin
              count_q     <= '0;
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= sum_d;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  localparam int RW = 8;
  localparam int VL = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_data;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
`ifdef DPA_OVERFLOW_EN
  logic          out_ovf;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  dot_product_accumulator #(
    .BIT_WIDTH    (4),
    .RESULT_WIDTH (RW),
    .VEC_LEN      (VL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DPA_OVERFLOW_EN
    .out_ovf   (out_ovf),
`endif
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum modulo 2^RW; overflow when any partial add exceeds the range.
  function automatic void ref_dot(input int unsigned t[VL], output int unsigned s, output bit ovf);
    int unsigned r;
    r   = 0;
    ovf = 1'b0;
    for (int i = 0; i < VL; i++) begin
      if (r + t[i] >= (1 << RW)) ovf = 1'b1;
      r = (r + t[i]) % (1 << RW);
    end
    s = r;
  endfunction

  // Feed one vector, hold the result for 'hold' cycles with out_ready low, then consume it.
  task automatic run_vec(input int unsigned t0, input int unsigned t1, input int unsigned t2,
                         input int unsigned t3, input int gapmax, input int gap1,
                         input int hold, input bit chk_ovf);
    int unsigned t[VL];
    int unsigned exp_s;
    bit          exp_o;
    int          g;
    t = '{t0, t1, t2, t3};
    ref_dot(t, exp_s, exp_o);
    out_ready = 1'b0;
    for (int i = 0; i < VL; i++) begin
      g = (i == 1) ? gap1 : 0;
      if (gapmax > 0) g += $urandom_range(0, gapmax);
      in_valid = 1'b0;
      in_data  = RW'($urandom);
      for (int k = 0; k < g; k++) begin
        tick();
        chk("out_valid_idle", out_valid, 0);
      end
      chk("in_ready_accum", in_ready, 1);
      in_valid = 1'b1;
      in_data  = RW'(t[i]);
      tick();
      in_valid = 1'b0;
      if (i < VL - 1) chk("out_valid_mid", out_valid, 0);
    end
    chk("out_valid_done", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("out_data", out_data, exp_s);
`ifdef DPA_OVERFLOW_EN
    if (chk_ovf) chk("out_ovf", out_ovf, exp_o);
`else
    if (chk_ovf && exp_o) n_checks += 0;
`endif
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("out_valid_hold", out_valid, 1);
      chk("out_data_hold", out_data, exp_s);
      chk("in_ready_hold", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_consumed", out_valid, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  task automatic accept_terms(input int n, input int unsigned base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = RW'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
`ifdef DPA_OVERFLOW_EN
    chk({tag, "_out_ovf"}, out_ovf, 0);
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    check_reset_vals("post_reset");

    // Back-to-back terms, immediate consume.
    run_vec(3, 5, 7, 9, 0, 0, 0, 1'b0);
    // Gap before the second term, result held for three cycles.
    run_vec(10, 0, 20, 30, 0, 2, 3, 1'b0);
    run_vec(1, 1, 1, 1, 0, 0, 0, 1'b0);
    // Wrap and overflow flag, then a clean vector.
    run_vec(200, 100, 0, 0, 0, 0, 0, 1'b1);
    run_vec(1, 2, 3, 4, 0, 0, 0, 1'b1);

    // Clear together with a presented term aborts the vector.
    accept_terms(1, 5);
    accept_terms(1, 6);
    in_valid = 1'b1;
    in_data  = 8'd7;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_out_valid", out_valid, 0);
    chk("clear_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("clear_idle_out_valid", out_valid, 0);
    end
    run_vec(1, 2, 3, 4, 0, 0, 0, 1'b1);

    // Asynchronous reset mid-vector.
    accept_terms(3, 40);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst_mid");
    #1 rst_n = 1'b1;
    tick();
    check_reset_vals("after_rst_mid");
    run_vec(2, 2, 2, 2, 0, 0, 0, 1'b1);

    // Asynchronous reset while holding a result.
    accept_terms(4, 50);
    chk("pre_rst_done_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst_done");
    #1 rst_n = 1'b1;
    tick();
    run_vec(2, 2, 2, 2, 0, 0, 0, 1'b1);

    // Clear in DONE beats a simultaneous consume.
    accept_terms(4, 9);
    chk("pre_clear_done_valid", out_valid, 1);
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    chk("clear_done_out_valid", out_valid, 0);
    chk("clear_done_in_ready", in_ready, 1);
    run_vec(7, 8, 9, 10, 0, 0, 0, 1'b1);

    // Randomized vectors with random gaps and backpressure.
    for (int v = 0; v < 30; v++) begin
      run_vec($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), 2, 0, $urandom_range(0, 3), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
